// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU among NREQ requesters.
// Each op passes through an operand register (S1) and a result register (S2).

module alu #(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       fn,
    input  logic [6:0]       funct7,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;
    logic           unused_funct7;

    assign shamt         = b[SHW-1:0];
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // fn follows RISC-V funct3; funct7[5] selects SUB and SRA.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' with a default first, so no latch is inferred.
        y = '0;
        case (fn)
            3'd0:    y = funct7[5] ? a - b : a + b;
            3'd1:    y = a << shamt;
            3'd2:    y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            3'd3:    y = {{(WIDTH-1){1'b0}}, a < b};
            3'd4:    y = a ^ b;
            3'd5:    y = funct7[5] ? WIDTH'($signed(a) >>> shamt) : a >> shamt;
            3'd6:    y = a | b;
            default: y = a & b;
        endcase
    end
endmodule

module alu_share_arbiter #(
    parameter  int WIDTH = 32,
    parameter  int NREQ  = 2,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*3-1:0]     req_fn,
    input  logic [NREQ*7-1:0]     req_funct7,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  busy
);
    logic             s1_valid;
    logic [2:0]       s1_fn;
    logic [6:0]       s1_funct7;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [IDW-1:0]   s1_id;
    logic             s2_valid;
    logic [IDW-1:0]   rr_ptr;

    logic [IDW-1:0]   grant;
    logic             grant_found;
    logic             drain;
    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic [WIDTH-1:0] alu_y;

    assign drain  = s2_valid & rsp_ready[rsp_id];
    assign s2_adv = !s2_valid | drain;
    assign s1_adv = !s1_valid | s2_adv;
    assign busy   = s1_valid | s2_valid;
    assign accept = |(req_valid & req_ready);

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int unsigned idx;
        logic [IDW-1:0] cand;
        idx         = 0;
        cand        = '0;
        grant       = rr_ptr;
        grant_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx  = (int'(rr_ptr) + k) % NREQ;
            cand = IDW'(idx);
            if (!grant_found && req_valid[cand]) begin
                grant       = cand;
                grant_found = 1'b1;
            end
        end
    end

    // Flush and reset both block a same-cycle accept.
    always_comb begin
        req_ready = '0;
        if (grant_found && s1_adv && !flush && rst_n)
            req_ready[grant] = 1'b1;
    end

    always_comb begin
        rsp_valid = '0;
        if (s2_valid)
            rsp_valid[rsp_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            rr_ptr   <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    rsp_data <= alu_y;
                    rsp_id   <= s1_id;
                end
            end
            if (s1_adv)
                s1_valid <= accept;
            if (accept)
                rr_ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
        end
    end

    // NOTE: operand registers carry no reset; s1_valid qualifies them, so only the control state is reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_fn     <= req_fn[grant*3 +: 3];
            s1_funct7 <= req_funct7[grant*7 +: 7];
            s1_a      <= req_a[grant*WIDTH +: WIDTH];
            s1_b      <= req_b[grant*WIDTH +: WIDTH];
            s1_id     <= grant;
        end
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .fn     (s1_fn),
        .funct7 (s1_funct7),
        .a      (s1_a),
        .b      (s1_b),
        .y      (alu_y)
    );
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: NREQ=2 and NREQ=3 instances
// compared against a queue-based model of the shared ALU pipeline.

module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, flush;
    logic [2:0]  req_valid, rsp_ready;
    logic [8:0]  req_fn;
    logic [20:0] req_funct7;
    logic [95:0] req_a, req_b;

    logic [1:0]  req_ready2, rsp_valid2;
    logic [0:0]  rsp_id2;
    logic [31:0] rsp_data2;
    logic        busy2;
    logic [2:0]  req_ready3, rsp_valid3;
    logic [1:0]  rsp_id3;
    logic [31:0] rsp_data3;
    logic        busy3;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(32), .NREQ(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid[1:0]), .req_ready(req_ready2),
        .req_fn(req_fn[5:0]), .req_funct7(req_funct7[13:0]),
        .req_a(req_a[63:0]), .req_b(req_b[63:0]),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready[1:0]),
        .rsp_id(rsp_id2), .rsp_data(rsp_data2), .busy(busy2)
    );

    alu_share_arbiter #(.WIDTH(32), .NREQ(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready3),
        .req_fn(req_fn), .req_funct7(req_funct7),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id3), .rsp_data(rsp_data3), .busy(busy3)
    );

    typedef struct {
        int          id;
        logic [31:0] res;
        bit          in_s2;
    } op_t;

    op_t q[$];
    int  rr = 0;
    int  n = 2;
    int  compared = 0;
    int  mismatched = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(logic [2:0] fn, logic [6:0] f7,
                                            logic [31:0] a, logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (fn)
            3'd0:    return f7[5] ? a + ~b + 32'd1 : a + b;
            3'd1:    return a << sh;
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return f7[5] ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic set_op(int i, logic [2:0] fn, logic [6:0] f7, logic [31:0] a, logic [31:0] b);
        req_fn[i*3 +: 3]     = fn;
        req_funct7[i*7 +: 7] = f7;
        req_a[i*32 +: 32]    = a;
        req_b[i*32 +: 32]    = b;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 3; i++)
            set_op(i, 3'($urandom), ($urandom_range(0, 2) == 0) ? 7'h20 : 7'($urandom_range(0, 1) * 7'h01),
                   $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
    endtask

    // One clock: check outputs at negedge against the model, then advance the model at posedge.
    task automatic step();
        logic [2:0]  o_ready, o_rv, exp_ready, exp_rv;
        logic [1:0]  o_id;
        logic [31:0] o_data;
        logic        o_busy;
        int          g;
        bit          drain, room;
        op_t         t;

        @(negedge clk);
        if (n == 2) begin
            o_ready = {1'b0, req_ready2}; o_rv = {1'b0, rsp_valid2};
            o_id = {1'b0, rsp_id2}; o_data = rsp_data2; o_busy = busy2;
        end else begin
            o_ready = req_ready3; o_rv = rsp_valid3;
            o_id = rsp_id3; o_data = rsp_data3; o_busy = busy3;
        end

        g = -1;
        for (int k = 0; k < n; k++)
            if (g < 0 && req_valid[(rr + k) % n]) g = (rr + k) % n;
        drain = q.size() > 0 && q[0].in_s2 && rsp_ready[q[0].id];
        room  = q.size() < 2 || drain;
        exp_ready = '0;
        if (g >= 0 && room && !flush && rst_n) exp_ready[g] = 1'b1;
        exp_rv = '0;
        if (q.size() > 0 && q[0].in_s2) exp_rv[q[0].id] = 1'b1;

        check("req_ready", 32'(o_ready), 32'(exp_ready));
        check("rsp_valid", 32'(o_rv), 32'(exp_rv));
        check("busy", 32'(o_busy), 32'(q.size() > 0));
        if (exp_rv != 0) begin
            check("rsp_id", 32'(o_id), 32'(q[0].id));
            check("rsp_data", o_data, q[0].res);
        end

        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            rr = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (drain) void'(q.pop_front());
            if (q.size() > 0) begin
                t = q[0]; t.in_s2 = 1'b1; q[0] = t;
            end
            if (g >= 0 && exp_ready[g]) begin
                t.id    = g;
                t.res   = ref_alu(req_fn[g*3 +: 3], req_funct7[g*7 +: 7], req_a[g*32 +: 32], req_b[g*32 +: 32]);
                t.in_s2 = 1'b0;
                q.push_back(t);
                rr = (g + 1) % n;
            end
        end
        #1;
    endtask

    task automatic rstep();
        rand_ops();
        step();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = '0; rsp_ready = 3'b111;
        req_fn = '0; req_funct7 = '0; req_a = '0; req_b = '0;

        // Reset state
        step(); step();
        check("rst_rsp_valid2", 32'(rsp_valid2), 0);
        check("rst_busy2", 32'(busy2), 0);
        check("rst_req_ready2", 32'(req_ready2), 0);
        check("rst_rsp_data2", rsp_data2, 0);
        check("rst_rsp_id2", 32'(rsp_id2), 0);
        check("rst_rsp_data3", rsp_data3, 0);
        check("rst_busy3", 32'(busy3), 0);
        rst_n = 1'b1;

        // Single op: 23 AND 11 from r0
        set_op(0, 3'd7, 7'd0, 32'd23, 32'd11);
        req_valid = 3'b001;
        step();
        req_valid = '0;
        step();
        check("single_rsp_valid", 32'(rsp_valid2), 32'b01);
        check("single_rsp_id", 32'(rsp_id2), 0);
        check("single_rsp_data", rsp_data2, 32'd3);
        step();
        check("single_busy_fall", 32'(busy2), 0);

        // Fairness from reset: r0 AND, r1 OR
        rst_n = 1'b0; step(); rst_n = 1'b1;
        set_op(0, 3'd7, 7'd0, 32'd23, 32'd11);
        set_op(1, 3'd6, 7'd0, 32'd23, 32'd11);
        req_valid = 3'b011;
        step(); step();
        check("fair_first_data", rsp_data2, 32'd3);
        step();
        check("fair_second_data", rsp_data2, 32'd31);
        check("fair_second_id", 32'(rsp_id2), 1);
        repeat (5) step();

        // Backpressure with S2 owned by r0 and S1 full
        for (int i = 0; i < 4 && !(q.size() == 2 && q[0].id == 0 && q[0].in_s2); i++) rstep();
        rsp_ready = 3'b110;
        repeat (5) rstep();
        check("bp_ready_zero", 32'(req_ready2), 0);
        rsp_ready = 3'b111;
        repeat (4) rstep();

        // Flush with both stages full
        flush = 1'b1;
        rstep();
        flush = 1'b0;
        check("flush_busy", 32'(busy2), 0);
        check("flush_rsp_valid", 32'(rsp_valid2), 0);
        rstep();
        repeat (3) rstep();

        // Reset while S2 holds an r1 result
        for (int i = 0; i < 4 && !(q.size() > 0 && q[0].id == 1 && q[0].in_s2); i++) rstep();
        rst_n = 1'b0;
        rstep();
        rst_n = 1'b1;
        check("midrst_busy", 32'(busy2), 0);
        check("midrst_rsp_valid", 32'(rsp_valid2), 0);
        req_valid = 3'b011;
        rstep();
        repeat (3) rstep();

        // Randomized traffic, NREQ=2
        repeat (300) begin
            req_valid = 3'($urandom);
            rsp_ready = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            flush     = ($urandom_range(0, 24) == 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            rstep();
        end
        flush = 1'b0; rst_n = 1'b1; req_valid = '0; rsp_ready = 3'b111;
        repeat (3) step();
        check("drain_busy2", 32'(busy2), 0);

        // NREQ=3: r2 alone twice, then all valid to exercise wrap-around
        n = 3;
        rst_n = 1'b0; step(); rst_n = 1'b1;
        req_valid = 3'b100;
        rstep(); rstep();
        req_valid = 3'b111;
        repeat (6) rstep();
        repeat (250) begin
            req_valid = 3'($urandom);
            rsp_ready = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            flush     = ($urandom_range(0, 24) == 0);
            rst_n     = ($urandom_range(0, 99) != 0);
            rstep();
        end
        flush = 1'b0; rst_n = 1'b1; req_valid = '0; rsp_ready = 3'b111;
        repeat (3) step();
        check("drain_busy3", 32'(busy3), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
